// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain: in-order post-decode pipeline tracker and hazard engine.
// Tracks STAGES slots (slot 0 = EX, then MEM, WB, ...). Provides two-port
// operand forwarding, load-use stall with bubble insertion, branch flush of
// the issuing instruction, and halt drain detection.
// Optional: define PIPE_PERF_CNT_EN to add retired_cnt / stall_cnt outputs.
module pipe_ctrl_chain #(
  parameter int unsigned STAGES     = 3,
  parameter int unsigned XLEN       = 64,
  parameter int unsigned RA_W       = 5,
  parameter int unsigned LOAD_STAGE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [RA_W-1:0] iss_rd,
  input  logic            iss_we,
  input  logic            iss_is_load,
  input  logic            iss_halt,
  input  logic [RA_W-1:0] rs1_addr,
  input  logic [RA_W-1:0] rs2_addr,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ld_data,
  input  logic            flush,
  output logic            stall,
  output logic            fwd1_hit,
  output logic [XLEN-1:0] fwd1_data,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd2_data,
  output logic            wb_valid,
  output logic [RA_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]     retired_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int unsigned LAST = STAGES - 1;

  // Per-slot pipeline state
  logic            slot_valid   [STAGES];
  logic [RA_W-1:0] slot_rd      [STAGES];
  logic            slot_we      [STAGES];
  logic            slot_is_load [STAGES];
  logic            slot_halt    [STAGES];
  logic [XLEN-1:0] slot_data    [STAGES];
  logic            slot_ready   [STAGES];

  logic            halt_seen;
  logic            halted_q;
  logic            issue;
  logic            hazard;

  // Youngest-match results per source port
  logic            m1, r1, m2, r2;
  logic [XLEN-1:0] d1, d2;

  // Result availability: EX results are never forwardable from slot 0,
  // loads only become forwardable once they reach LOAD_STAGE.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      slot_ready[k] = 1'b1;
      if (k == 0)
        slot_ready[k] = 1'b0;
      else if (slot_is_load[k] && (k < LOAD_STAGE))
        slot_ready[k] = 1'b0;
    end
  end

  // Forwarding search: walk oldest to youngest so the youngest match wins.
  always_comb begin
    m1 = 1'b0;
    r1 = 1'b0;
    d1 = '0;
    m2 = 1'b0;
    r2 = 1'b0;
    d2 = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (slot_valid[LAST-i] && slot_we[LAST-i] &&
          (slot_rd[LAST-i] == rs1_addr) && (rs1_addr != '0)) begin
        m1 = 1'b1;
        r1 = slot_ready[LAST-i];
        d1 = slot_data[LAST-i];
      end
      if (slot_valid[LAST-i] && slot_we[LAST-i] &&
          (slot_rd[LAST-i] == rs2_addr) && (rs2_addr != '0)) begin
        m2 = 1'b1;
        r2 = slot_ready[LAST-i];
        d2 = slot_data[LAST-i];
      end
    end
  end

  assign hazard    = (m1 & ~r1) | (m2 & ~r2);
  assign stall     = hazard & ~flush;
  assign issue     = iss_valid & ~stall & ~flush & ~halt_seen;

  assign fwd1_hit  = m1 & r1;
  assign fwd1_data = fwd1_hit ? d1 : '0;
  assign fwd2_hit  = m2 & r2;
  assign fwd2_data = fwd2_hit ? d2 : '0;

  assign wb_valid  = slot_valid[LAST] & slot_we[LAST] & (slot_rd[LAST] != '0);
  assign wb_rd     = slot_rd[LAST];
  assign wb_data   = slot_data[LAST];

  assign halted    = halted_q | (slot_valid[LAST] & slot_halt[LAST]);

  // Slot shift register: slot 0 takes the issue (or a bubble), all others advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        slot_valid[k]   <= 1'b0;
        slot_rd[k]      <= '0;
        slot_we[k]      <= 1'b0;
        slot_is_load[k] <= 1'b0;
        slot_halt[k]    <= 1'b0;
        slot_data[k]    <= '0;
      end
    end else begin
      slot_valid[0]   <= issue;
      slot_rd[0]      <= issue ? iss_rd : '0;
      slot_we[0]      <= issue & iss_we;
      slot_is_load[0] <= issue & iss_is_load;
      slot_halt[0]    <= issue & iss_halt;
      slot_data[0]    <= '0;
      for (int unsigned k = 1; k < STAGES; k++) begin
        slot_valid[k]   <= slot_valid[k-1];
        slot_rd[k]      <= slot_rd[k-1];
        slot_we[k]      <= slot_we[k-1];
        slot_is_load[k] <= slot_is_load[k-1];
        slot_halt[k]    <= slot_halt[k-1];
        // Load return overrides the EX capture when LOAD_STAGE is slot 1.
        if ((k == LOAD_STAGE) && slot_is_load[k-1])
          slot_data[k] <= ld_data;
        else if (k == 1)
          slot_data[k] <= ex_result;
        else
          slot_data[k] <= slot_data[k-1];
      end
    end
  end

  // Halt bookkeeping: issue block after a halt, sticky drain indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_seen <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      if (issue && iss_halt)
        halt_seen <= 1'b1;
      if (halted)
        halted_q <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Performance counters: retirements out of the last slot and stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (slot_valid[LAST])
        retired_cnt <= retired_cnt + 32'd1;
      if (stall)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
